// File: rtl/riscv_hazard_pkg.sv
// riscv_hazard_pkg: forwarding select codes and stall FSM encoding shared by the hazard unit
package riscv_hazard_pkg;
    localparam logic [1:0] FWD_NONE   = 2'b00;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_BUBBLE = 2'd1,
        MEM_WAIT  = 2'd2
    } state_e;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: one operand's forwarding comparator, EX/MEM beats MEM/WB, x0 never forwarded
module fwd_select
    import riscv_hazard_pkg::*;
#(
    parameter int RW = 5
) (
    input  logic [RW-1:0] rs,
    input  logic [RW-1:0] ex_mem_rd,
    input  logic          ex_mem_regwrite,
    input  logic [RW-1:0] mem_wb_rd,
    input  logic          mem_wb_regwrite,
    output logic [1:0]    sel
);
    assign sel = (ex_mem_regwrite && ex_mem_rd != '0 && ex_mem_rd == rs) ? FWD_EX_MEM :
                 (mem_wb_regwrite && mem_wb_rd != '0 && mem_wb_rd == rs) ? FWD_MEM_WB : FWD_NONE;
endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: per-operand forwarding plus load-use / memory-wait stall FSM and stall counter
module hazard_forward_unit
    import riscv_hazard_pkg::*;
#(
    parameter int RW      = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC*RW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]    id_rs_used,
    input  logic [NUM_SRC*RW-1:0] ex_rs,
    input  logic [RW-1:0]         id_ex_rd,
    input  logic                  id_ex_memread,
    input  logic [RW-1:0]         ex_mem_rd,
    input  logic                  ex_mem_regwrite,
    input  logic [RW-1:0]         mem_wb_rd,
    input  logic                  mem_wb_regwrite,
    input  logic                  mem_busy,
    input  logic                  stall_cnt_clr,
    output logic [2*NUM_SRC-1:0]  fwd_sel,
    output logic                  pc_write_en,
    output logic                  if_id_write_en,
    output logic                  id_ex_bubble,
    output logic                  pipe_freeze,
    output logic [CNT_W-1:0]      stall_count
);
    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic load_use;

    genvar i;
    generate
        for (i = 0; i < NUM_SRC; i++) begin : g_fwd
            fwd_select #(.RW(RW)) u_fwd (
                .rs              (ex_rs[i*RW +: RW]),
                .ex_mem_rd       (ex_mem_rd),
                .ex_mem_regwrite (ex_mem_regwrite),
                .mem_wb_rd       (mem_wb_rd),
                .mem_wb_regwrite (mem_wb_regwrite),
                .sel             (fwd_sel[2*i +: 2])
            );
        end
    endgenerate

    always_comb begin
        load_use = 1'b0;
        for (int j = 0; j < NUM_SRC; j++)
            load_use = load_use | (id_ex_memread && id_ex_rd != '0 &&
                                   id_ex_rd == id_rs[j*RW +: RW] && id_rs_used[j]);
    end

    // Busy memory freezes from any state; a bubble is only inserted from RUN so LU_BUBBLE never repeats it.
    always_comb begin
        pipe_freeze    = rst_n && mem_busy;
        id_ex_bubble   = rst_n && !mem_busy && state_q == RUN && load_use;
        pc_write_en    = !(pipe_freeze || id_ex_bubble);
        if_id_write_en = pc_write_en;
        state_d        = mem_busy ? MEM_WAIT : id_ex_bubble ? LU_BUBBLE : RUN;
        cnt_d          = stall_cnt_clr ? '0 :
                         (!pc_write_en && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_count = cnt_q;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed checks of forwarding, load-use bubble, memory wait and stall counter
module tb_hazard_forward_unit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] id_rs;
    logic [1:0] id_rs_used;
    logic [9:0] ex_rs;
    logic [4:0] id_ex_rd;
    logic       id_ex_memread;
    logic [4:0] ex_mem_rd;
    logic       ex_mem_regwrite;
    logic [4:0] mem_wb_rd;
    logic       mem_wb_regwrite;
    logic       mem_busy;
    logic       stall_cnt_clr;
    logic [3:0] fwd_sel, fwd_sel_s;
    logic       pc_write_en, if_id_write_en, id_ex_bubble, pipe_freeze;
    logic       pc_write_en_s, if_id_write_en_s, id_ex_bubble_s, pipe_freeze_s;
    logic [15:0] stall_count;
    logic [1:0]  stall_count_s;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_forward_unit dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_rs(ex_rs),
        .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread), .ex_mem_rd(ex_mem_rd),
        .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
        .mem_busy(mem_busy), .stall_cnt_clr(stall_cnt_clr), .fwd_sel(fwd_sel),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .id_ex_bubble(id_ex_bubble),
        .pipe_freeze(pipe_freeze), .stall_count(stall_count)
    );

    hazard_forward_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_rs(ex_rs),
        .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread), .ex_mem_rd(ex_mem_rd),
        .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
        .mem_busy(mem_busy), .stall_cnt_clr(stall_cnt_clr), .fwd_sel(fwd_sel_s),
        .pc_write_en(pc_write_en_s), .if_id_write_en(if_id_write_en_s), .id_ex_bubble(id_ex_bubble_s),
        .pipe_freeze(pipe_freeze_s), .stall_count(stall_count_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_busy = 1'b1;
        tick(); tick();
        checks++;
        if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", stall_count); end
        checks++;
        if ({pc_write_en, if_id_write_en, id_ex_bubble, pipe_freeze} !== 4'b1100) begin
            errors++; $display("FAIL reset_outputs: got %b want 1100", {pc_write_en, if_id_write_en, id_ex_bubble, pipe_freeze});
        end
        mem_busy = 1'b0; rst_n = 1'b1;
        tick();
        checks++;
        if ({pc_write_en, id_ex_bubble, pipe_freeze} !== 3'b100) begin
            errors++; $display("FAIL run_idle: got %b want 100", {pc_write_en, id_ex_bubble, pipe_freeze});
        end
    endtask

    task automatic test_forward();
        ex_rs = {5'd0, 5'd5}; ex_mem_rd = 5'd5; ex_mem_regwrite = 1'b1; mem_wb_rd = 5'd5; mem_wb_regwrite = 1'b1;
        #1 checks++;
        if (fwd_sel !== 4'b0010) begin errors++; $display("FAIL fwd_ex_mem_prio: got %b want 0010", fwd_sel); end
        ex_mem_regwrite = 1'b0;
        #1 checks++;
        if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL fwd_mem_wb: got %b want 0001", fwd_sel); end
        ex_mem_rd = 5'd0; ex_mem_regwrite = 1'b1;
        #1 checks++;
        if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL fwd_x0_ex_mem: got %b want 0001", fwd_sel); end
        ex_rs = {5'd9, 5'd0}; ex_mem_rd = 5'd9; mem_wb_rd = 5'd0;
        #1 checks++;
        if (fwd_sel !== 4'b1000) begin errors++; $display("FAIL fwd_op1_x0_wb: got %b want 1000", fwd_sel); end
        ex_mem_regwrite = 1'b0; mem_wb_rd = 5'd9;
        #1 checks++;
        if (fwd_sel !== 4'b0100) begin errors++; $display("FAIL fwd_op1_wb: got %b want 0100", fwd_sel); end
        mem_wb_regwrite = 1'b0;
        #1 checks++;
        if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL fwd_none: got %b want 0000", fwd_sel); end
    endtask

    task automatic test_load_use();
        id_ex_memread = 1'b1; id_ex_rd = 5'd7; id_rs = {5'd7, 5'd3}; id_rs_used = 2'b11;
        #1 checks++;
        if ({pc_write_en, if_id_write_en, id_ex_bubble, pipe_freeze} !== 4'b0010) begin
            errors++; $display("FAIL lu_bubble: got %b want 0010", {pc_write_en, if_id_write_en, id_ex_bubble, pipe_freeze});
        end
        tick();
        checks++;
        if ({pc_write_en, id_ex_bubble} !== 2'b10) begin
            errors++; $display("FAIL lu_single_bubble: got %b want 10", {pc_write_en, id_ex_bubble});
        end
        checks++;
        if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_count: got %0d want 1", stall_count); end
        id_ex_memread = 1'b0;
        tick();
        id_ex_memread = 1'b1; id_rs_used = 2'b01;
        #1 checks++;
        if ({pc_write_en, id_ex_bubble} !== 2'b10) begin
            errors++; $display("FAIL lu_unused: got %b want 10", {pc_write_en, id_ex_bubble});
        end
        id_ex_rd = 5'd0; id_rs = {5'd0, 5'd0}; id_rs_used = 2'b11;
        #1 checks++;
        if ({pc_write_en, id_ex_bubble} !== 2'b10) begin
            errors++; $display("FAIL lu_x0: got %b want 10", {pc_write_en, id_ex_bubble});
        end
        id_ex_rd = 5'd3; id_rs = {5'd7, 5'd3}; id_rs_used = 2'b01;
        #1 checks++;
        if ({pc_write_en, id_ex_bubble} !== 2'b01) begin
            errors++; $display("FAIL lu_op0: got %b want 01", {pc_write_en, id_ex_bubble});
        end
        tick();
        id_ex_memread = 1'b0;
        tick();
        checks++;
        if (stall_count !== 16'd2) begin errors++; $display("FAIL lu_count2: got %0d want 2", stall_count); end
    endtask

    task automatic test_busy_and_load_use();
        stall_cnt_clr = 1'b1;
        tick();
        stall_cnt_clr = 1'b0;
        checks++;
        if (stall_count !== 16'd0) begin errors++; $display("FAIL clr_count: got %0d want 0", stall_count); end
        id_ex_memread = 1'b1; id_ex_rd = 5'd7; id_rs = {5'd7, 5'd3}; id_rs_used = 2'b11; mem_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 checks++;
            if ({pc_write_en, id_ex_bubble, pipe_freeze} !== 3'b001) begin
                errors++; $display("FAIL busy_freeze%0d: got %b want 001", k, {pc_write_en, id_ex_bubble, pipe_freeze});
            end
            tick();
        end
        mem_busy = 1'b0;
        #1 checks++;
        if ({pc_write_en, id_ex_bubble, pipe_freeze} !== 3'b100) begin
            errors++; $display("FAIL busy_release: got %b want 100", {pc_write_en, id_ex_bubble, pipe_freeze});
        end
        tick();
        checks++;
        if ({pc_write_en, id_ex_bubble, pipe_freeze} !== 3'b010) begin
            errors++; $display("FAIL busy_then_bubble: got %b want 010", {pc_write_en, id_ex_bubble, pipe_freeze});
        end
        tick();
        checks++;
        if (stall_count !== 16'd4) begin errors++; $display("FAIL busy_count: got %0d want 4", stall_count); end
        id_ex_memread = 1'b0;
        tick();
    endtask

    task automatic test_saturate_and_reset();
        stall_cnt_clr = 1'b1;
        tick();
        stall_cnt_clr = 1'b0; mem_busy = 1'b1;
        repeat (5) tick();
        checks++;
        if (stall_count_s !== 2'd3) begin errors++; $display("FAIL sat_count: got %0d want 3", stall_count_s); end
        checks++;
        if (stall_count !== 16'd5) begin errors++; $display("FAIL wide_count: got %0d want 5", stall_count); end
        stall_cnt_clr = 1'b1;
        tick();
        stall_cnt_clr = 1'b0;
        checks++;
        if (stall_count_s !== 2'd0) begin errors++; $display("FAIL clr_during_stall: got %0d want 0", stall_count_s); end
        tick();
        checks++;
        if (stall_count !== 16'd1) begin errors++; $display("FAIL count_after_clr: got %0d want 1", stall_count); end
        rst_n = 1'b0;
        #1 checks++;
        if ({pc_write_en, if_id_write_en, id_ex_bubble, pipe_freeze} !== 4'b1100) begin
            errors++; $display("FAIL reset_mid_wait: got %b want 1100", {pc_write_en, if_id_write_en, id_ex_bubble, pipe_freeze});
        end
        tick();
        rst_n = 1'b1; mem_busy = 1'b0;
        id_ex_memread = 1'b1; id_ex_rd = 5'd7; id_rs = {5'd7, 5'd3}; id_rs_used = 2'b10;
        #1 checks++;
        if ({pc_write_en, id_ex_bubble, pipe_freeze} !== 3'b010) begin
            errors++; $display("FAIL reset_back_to_run: got %b want 010", {pc_write_en, id_ex_bubble, pipe_freeze});
        end
        checks++;
        if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_mid_count: got %0d want 0", stall_count); end
        tick();
        id_ex_memread = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; id_rs = '0; id_rs_used = '0; ex_rs = '0; id_ex_rd = '0; id_ex_memread = 1'b0;
        ex_mem_rd = '0; ex_mem_regwrite = 1'b0; mem_wb_rd = '0; mem_wb_regwrite = 1'b0;
        mem_busy = 1'b0; stall_cnt_clr = 1'b0;
        test_reset();
        test_forward();
        test_load_use();
        test_busy_and_load_use();
        test_saturate_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
